div_iter_param: RTL
===================

Name: div_iter_param

Overview:
- Parametrised multi-cycle iterative restoring divider for the EX stage.
- Signed or unsigned division of two WIDTH-bit operands, returning quotient and remainder.
- Handles STEPS quotient bits per clock, flags divide-by-zero, supports annul, and holds the result until EX releases it.
- Successor to the fixed 32-bit, 1-bit-per-cycle divider. Adds width/throughput generalisation, a zero flag, a busy output and a separate sign-fix cycle.

Parameters:
- WIDTH, 32: operand width. Must be even and at least 4.
- STEPS, 1: quotient bits per cycle, one of 1, 2 or 4. WIDTH % STEPS == 0.
- N (localparam), WIDTH/STEPS: number of iteration cycles.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- signed_div_i  in  1  1 = two's-complement operands
- opdata1_i  in  WIDTH  dividend; must be held stable from start until ready_o
- opdata2_i  in  WIDTH  divisor; must be held stable from start until ready_o
- start_i  in  1  level request; dropping it to 0 in DONE releases the result
- annul_i  in  1  cancel the current operation
- quotient_o  out  WIDTH  registered quotient
- remainder_o  out  WIDTH  registered remainder
- div_zero_o  out  1  divisor was 0 (valid while ready_o)
- busy_o  out  1  high in CALC and FIX
- ready_o  out  1  result valid

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; quotient_o, remainder_o, div_zero_o, ready_o, busy_o all 0; iteration counter 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start_i=1 and annul_i=0, divisor==0: go to DONE; latch div_zero=1, quotient=0, remainder=0.
  - start_i=1 and annul_i=0, divisor!=0: latch magnitudes |op1| and |op2| (negated only when signed_div_i=1 and MSB=1). Latch neg_q = op1[MSB]^op2[MSB] and neg_r = op1[MSB], both gated by signed_div_i. Clear the partial remainder and counter. Go to CALC.
  - Otherwise: stay in IDLE with outputs 0.
- CALC:
  - Each cycle applies STEPS chained restoring steps:
    - Shift the partial remainder left by 1, bringing in the next dividend MSB.
    - trial = rem - divisor, computed WIDTH+1 bits wide.
    - If trial is non-negative, rem = trial and the quotient bit is 1; otherwise the quotient bit is 0.
  - Counter increments each cycle. After N cycles go to FIX.
- FIX (one cycle): negate the quotient if neg_q and the remainder if neg_r, modulo 2^WIDTH. Go to DONE.
- Results:
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Signed MIN / -1 gives quotient = MIN (wraps) and remainder = 0, with no trap.
- DONE:
  - ready_o=1; quotient_o, remainder_o and div_zero_o are registered and stable.
  - When start_i=0, the next cycle is IDLE with all outputs cleared.
- Annul:
  - annul_i=1 in CALC or FIX: next state IDLE, ready_o stays 0, outputs 0.
  - annul_i=1 in DONE: next state IDLE, outputs cleared.
  - annul_i has priority over start_i.
- Latency, start sampled in cycle 0: ready_o rises at the edge ending cycle N+1, i.e. first visible in cycle N+2. Divide-by-zero: ready_o first visible in cycle 1.
- busy_o = (state==CALC || state==FIX). ready_o and busy_o are never both 1.
- Operands must stay stable until ready_o. The latched sign flags make a change after start harmless.
- Reset asserted mid-operation: immediate return to IDLE with every output at 0.

Decomposition:
- div_pkg holds:
  - state encoding: DIV_IDLE=2'b00, DIV_CALC=2'b01, DIV_FIX=2'b10, DIV_DONE=2'b11
  - DIV_START/DIV_STOP level constants
  - RESULT_READY/NOT_READY constants
- Sub-module div_step: combinational single restoring step.
  - Parameter WIDTH.
  - Inputs rem, divisor, next dividend bit.
  - Outputs new rem and quotient bit.
  - Instantiated STEPS times in a chain by a generate loop.

Test Plan:
- WIDTH=32, STEPS=1, unsigned, 100 / 7 -> quotient=14, remainder=2; ready_o first seen 34 cycles after the start cycle; busy_o high for 33 cycles.
- Signed -7 / 2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0.
- Divisor 0 (op1=0x1234) -> div_zero_o=1, quotient=0, remainder=0, ready_o in cycle 1. Then start_i=0 -> IDLE with outputs 0 on the next cycle.
- Annul at CALC cycle 10 -> IDLE on the next cycle, ready_o never asserts. A new start 5/5 afterwards -> quotient=1, remainder=0 with no residue from the aborted operation.
- STEPS=4, WIDTH=16, unsigned 0xFFFF / 0x0003 -> quotient=0x5555, remainder=0, ready_o first seen in cycle 6.
- Reset pulsed during CALC -> all outputs 0 asynchronously, without a clock edge. Result held in DONE for 20 cycles with start_i=1 -> outputs unchanged throughout.

Source files
------------

// File: rtl/div_pkg.sv
// Shared encodings for the iterative divider: FSM states and control-level constants.
package div_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_CALC = 2'b01,
    DIV_FIX  = 2'b10,
    DIV_DONE = 2'b11
  } div_state_t;

  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP  = 1'b0;

  localparam logic RESULT_READY     = 1'b1;
  localparam logic RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract, keep or restore.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] divisor,
  input  logic             dvd_bit,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  assign shifted = {rem, dvd_bit};
  assign trial   = shifted - {1'b0, divisor};

  // rem < divisor on entry, so a successful subtraction always fits in WIDTH bits
  assign q_bit    = ~trial[WIDTH];
  assign rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];

endmodule

// File: rtl/div_iter_param.sv
// Iterative restoring divider, STEPS quotient bits per clock, signed/unsigned, with annul and hold-until-release.
//
// state | meaning
// IDLE  | waiting for start, outputs cleared
// CALC  | N iteration cycles, STEPS restoring steps each
// FIX   | apply quotient/remainder sign correction
// DONE  | result held, ready_o high until start_i drops or annul
module div_iter_param
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEPS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             signed_div_i,
  input  logic [WIDTH-1:0] opdata1_i,
  input  logic [WIDTH-1:0] opdata2_i,
  input  logic             start_i,
  input  logic             annul_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_zero_o,
  output logic             busy_o,
  output logic             ready_o
);

  localparam int N  = WIDTH / STEPS;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  div_state_t       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] dsr_r;
  logic             neg_q;
  logic             neg_r;

  logic             op1_neg;
  logic             op2_neg;
  logic [WIDTH-1:0] op1_abs;
  logic [WIDTH-1:0] op2_abs;

  assign op1_neg = signed_div_i & opdata1_i[WIDTH-1];
  assign op2_neg = signed_div_i & opdata2_i[WIDTH-1];
  assign op1_abs = op1_neg ? -opdata1_i : opdata1_i;
  assign op2_abs = op2_neg ? -opdata2_i : opdata2_i;

  // dvd_r shifts out dividend bits at the top while quotient bits fill in at the bottom
  logic [STEPS:0][WIDTH-1:0] rem_c;
  logic [STEPS:0][WIDTH-1:0] dvd_c;

  assign rem_c[0] = rem_r;
  assign dvd_c[0] = dvd_r;

  for (genvar g = 0; g < STEPS; g++) begin : g_step
    logic qb;
    div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem_c[g]),
      .divisor  (dsr_r),
      .dvd_bit  (dvd_c[g][WIDTH-1]),
      .rem_next (rem_c[g+1]),
      .q_bit    (qb)
    );
    assign dvd_c[g+1] = {dvd_c[g][WIDTH-2:0], qb};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= DIV_IDLE;
      cnt         <= '0;
      rem_r       <= '0;
      dvd_r       <= '0;
      dsr_r       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
      div_zero_o  <= 1'b0;
      busy_o      <= 1'b0;
      ready_o     <= RESULT_NOT_READY;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start_i == DIV_START && !annul_i) begin
            if (opdata2_i == '0) begin
              state       <= DIV_DONE;
              div_zero_o  <= 1'b1;
              quotient_o  <= '0;
              remainder_o <= '0;
              ready_o     <= RESULT_READY;
            end else begin
              state  <= DIV_CALC;
              dvd_r  <= op1_abs;
              dsr_r  <= op2_abs;
              rem_r  <= '0;
              cnt    <= '0;
              neg_q  <= op1_neg ^ op2_neg;
              neg_r  <= op1_neg;
              busy_o <= 1'b1;
            end
          end
        end
        DIV_CALC: begin
          if (annul_i) begin
            state  <= DIV_IDLE;
            busy_o <= 1'b0;
          end else begin
            rem_r <= rem_c[STEPS];
            dvd_r <= dvd_c[STEPS];
            cnt   <= cnt + 1'b1;
            if (cnt == LAST) state <= DIV_FIX;
          end
        end
        DIV_FIX: begin
          busy_o <= 1'b0;
          if (annul_i) begin
            state <= DIV_IDLE;
          end else begin
            state       <= DIV_DONE;
            quotient_o  <= neg_q ? -dvd_r : dvd_r;
            remainder_o <= neg_r ? -rem_r : rem_r;
            ready_o     <= RESULT_READY;
          end
        end
        DIV_DONE: begin
          if (annul_i || start_i == DIV_STOP) begin
            state       <= DIV_IDLE;
            quotient_o  <= '0;
            remainder_o <= '0;
            div_zero_o  <= 1'b0;
            ready_o     <= RESULT_NOT_READY;
          end
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

endmodule
